// File: rtl/ib_pkg.sv
// ib_pkg: shared types and defaults for the input-buffer drain controller.
//   q_state_t   : output-queue occupancy states
//   DATA_WIDTH_DEF, DEST_MSB_DEF, DEST_LSB_DEF : default word/destination layout
//   STAT_WIDTH  : width of the optional statistics counters
package ib_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned DEST_MSB_DEF   = 15;
    localparam int unsigned DEST_LSB_DEF   = 13;
    localparam int unsigned STAT_WIDTH     = 16;

    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_TWO} q_state_t;

    // Number of words held in the output queue for a given occupancy state.
    function automatic logic [1:0] state_count(input q_state_t s);
        case (s)
            Q_ONE:   return 2'd1;
            Q_TWO:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/drain_queue2.sv
// drain_queue2: two-entry in-order word store.
//   clk, reset   : clock, asynchronous active-low reset
//   wr_i         : append wr_data_i at the tail this edge
//   pop_i        : remove the head this edge (only when count_o != 0)
//   count_o      : words currently held (0..2)
//   head_o       : oldest word (registered)
module drain_queue2
    import ib_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (wr_i) begin
                    head_d  = wr_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (wr_i && pop_i) begin
                    // head leaves and the new word becomes the head directly
                    head_d = wr_data_i;
                end else if (wr_i) begin
                    tail_d  = wr_data_i;
                    count_d = 2'd2;
                end else if (pop_i) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (wr_i) begin
                        tail_d = wr_data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/input_drain_ctrl.sv
// input_drain_ctrl: pops the input buffer FIFO (1-cycle read latency) and
// presents words downstream on valid/ready through a 2-entry output queue.
//   clk, reset      : clock, asynchronous active-low reset
//   buf_empty_i     : buffer empty flag (same cycle)
//   buf_data_i      : buffer read data, valid the cycle after buf_read_o
//   buf_read_o      : pop request to the buffer
//   out_ready_i     : downstream accepts
//   out_valid_o     : out_data_o / out_dest_o valid
//   out_data_o      : head-of-queue word
//   out_dest_o      : out_data_o[DEST_MSB:DEST_LSB]
// Optional (macro DRAIN_STATS_EN):
//   stat_words_o    : saturating count of words popped
//   stat_stall_o    : saturating count of valid & !ready cycles
module input_drain_ctrl
    import ib_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEST_MSB   = DEST_MSB_DEF,
    parameter int unsigned DEST_LSB   = DEST_LSB_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         buf_empty_i,
    input  logic [DATA_WIDTH-1:0]        buf_data_i,
    output logic                         buf_read_o,
    input  logic                         out_ready_i,
    output logic                         out_valid_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic [DEST_MSB-DEST_LSB:0]   out_dest_o
`ifdef DRAIN_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]        stat_words_o,
    output logic [STAT_WIDTH-1:0]        stat_stall_o
`endif
);

    q_state_t              q_state_q, q_state_d;
    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic                  issue;
    logic                  write;
    logic [2:0]            occupancy;
    logic [2:0]            limit;
    logic [1:0]            q_count;
    logic [DATA_WIDTH-1:0] q_head;

    assign out_valid_o = (q_state_q != Q_EMPTY);
    assign pop         = out_valid_o & out_ready_i;
    assign write       = inflight_q;

    // count + inflight - pop < 2, rearranged to avoid unsigned underflow
    assign occupancy = {1'b0, state_count(q_state_q)} + {2'b00, inflight_q};
    assign limit     = 3'd2 + {2'b00, pop};

    always_comb begin
        q_state_d  = q_state_q;
        issue      = reset & ~buf_empty_i & (occupancy < limit);
        inflight_d = issue;
        case (q_state_q)
            Q_EMPTY: if (write)          q_state_d = Q_ONE;
            Q_ONE: begin
                if (write && !pop)       q_state_d = Q_TWO;
                else if (!write && pop)  q_state_d = Q_EMPTY;
            end
            Q_TWO: if (!write && pop)    q_state_d = Q_ONE;
            default:                     q_state_d = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_state_q  <= Q_EMPTY;
            inflight_q <= 1'b0;
        end else begin
            q_state_q  <= q_state_d;
            inflight_q <= inflight_d;
        end
    end

    assign buf_read_o = issue;

    drain_queue2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (write),
        .wr_data_i (buf_data_i),
        .pop_i     (pop),
        .count_o   (q_count),
        .head_o    (q_head)
    );

    assign out_data_o = q_head;
    assign out_dest_o = q_head[DEST_MSB:DEST_LSB];

    a_no_overfill: assert property (@(posedge clk) disable iff (!reset)
        !(q_state_q == Q_TWO && write && !pop));

    a_count_match: assert property (@(posedge clk) disable iff (!reset)
        q_count == state_count(q_state_q));

`ifdef DRAIN_STATS_EN
    logic [STAT_WIDTH-1:0] stat_words_q, stat_words_d;
    logic [STAT_WIDTH-1:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_words_d = stat_words_q;
        stat_stall_d = stat_stall_q;
        if (pop && stat_words_q != '1) begin
            stat_words_d = stat_words_q + STAT_ONE;
        end
        if (out_valid_o && !out_ready_i && stat_stall_q != '1) begin
            stat_stall_d = stat_stall_q + STAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_words_o = stat_words_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_input_drain_ctrl.sv
module tb_input_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        buf_empty_i = 1'b1;
    logic [15:0] buf_data_i = '0;
    logic        buf_read_o;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [15:0] out_data_o;
    logic [2:0]  out_dest_o;
`ifdef DRAIN_STATS_EN
    logic [15:0] stat_words_o;
    logic [15:0] stat_stall_o;
`endif

    input_drain_ctrl #(
        .DATA_WIDTH (16),
        .DEST_MSB   (15),
        .DEST_LSB   (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buf_empty_i (buf_empty_i),
        .buf_data_i  (buf_data_i),
        .buf_read_o  (buf_read_o),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_dest_o  (out_dest_o)
`ifdef DRAIN_STATS_EN
        ,
        .stat_words_o (stat_words_o),
        .stat_stall_o (stat_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: buffer contents, words expected downstream in order,
    // and the word the buffer returns one cycle after a read.
    logic [15:0] bufq[$];
    logic [15:0] expq[$];
    logic [15:0] pending;
    bit          pending_v = 1'b0;
    int          reads_total = 0;
    int          pops_total  = 0;
    int          valid_cycles = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_word(input logic [15:0] w);
        bufq.push_back(w);
        expq.push_back(w);
    endfunction

    function automatic void clear_model();
        bufq.delete();
        expq.delete();
        pending_v    = 1'b0;
        reads_total  = 0;
        pops_total   = 0;
        valid_cycles = 0;
    endfunction

    // One clock cycle of the buffer model plus downstream ready.
    task automatic step(input bit rdy);
        @(negedge clk);
        buf_data_i  = pending_v ? pending : 16'($urandom);
        pending_v   = 1'b0;
        out_ready_i = rdy;
        buf_empty_i = (bufq.size() == 0);
        #1;
        if (out_valid_o) valid_cycles++;
        if (buf_read_o) begin
            reads_total++;
            check("read_while_empty", buf_empty_i, 0);
            if (bufq.size() != 0) begin
                pending   = bufq.pop_front();
                pending_v = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_buf_read"}, buf_read_o, 0);
        check({tag, "_valid"},    out_valid_o, 0);
        check({tag, "_data"},     out_data_o, 0);
        check({tag, "_dest"},     out_dest_o, 0);
    endtask

    // Monitor: every accepted word is matched against the scoreboard.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (out_valid_o && out_ready_i) begin
                    pops_total++;
                    if (expq.size() == 0) begin
                        check("unexpected_word", out_data_o, 0);
                        check("unexpected_word_cnt", expq.size(), 1);
                    end else begin
                        e = expq.pop_front();
                        check("data", out_data_o, e);
                        check("dest", out_dest_o, e >> 13);
                    end
                end
                check("overread", ((reads_total - pops_total) <= 2) ? 1 : 0, 1);
            end
        end
    end

    initial begin
        int r0;
        int p0;
        int v0;
        logic [15:0] w0;

        // Power-on reset
        #1;
        check_reset_outputs("por");
        repeat (2) step(0);
        reset = 1'b1;

        // Three words, continuous ready: valid from the third cycle
        push_word(16'hA001);
        push_word(16'h2002);
        push_word(16'h6003);
        p0 = pops_total;
        step(1);
        check("t2_read_n",   buf_read_o, 1);
        check("t2_valid_n",  out_valid_o, 0);
        step(1);
        check("t2_valid_n1", out_valid_o, 0);
        step(1);
        check("t2_valid_n2", out_valid_o, 1);
        check("t2_dest0",    out_dest_o, 5);
        step(1);
        check("t2_dest1",    out_dest_o, 1);
        step(1);
        check("t2_dest2",    out_dest_o, 3);
        step(1);
        check("t2_pops",     pops_total - p0, 3);
        check("t2_valid_end", out_valid_o, 0);

        // Backpressure: five words, ready low
        w0 = 16'($urandom);
        push_word(w0);
        for (int unsigned i = 1; i < 5; i++) push_word(16'($urandom));
        r0 = reads_total;
        repeat (10) step(0);
        check("t3_reads",    reads_total - r0, 2);
        check("t3_valid",    out_valid_o, 1);
        check("t3_head",     out_data_o, w0);
        p0 = pops_total;
        repeat (6) step(1);
        check("t3_burst",    pops_total - p0, 5);
        check("t3_valid_end", out_valid_o, 0);

        // Ready toggling over eight words
        for (int unsigned i = 0; i < 8; i++) push_word(16'($urandom));
        p0 = pops_total;
        for (int unsigned i = 0; i < 30; i++) step(i[0] == 1'b0);
        check("t4_pops",  pops_total - p0, 8);
        check("t4_drain", expq.size(), 0);

        // Single word
        push_word(16'h1234);
        r0 = reads_total;
        v0 = valid_cycles;
        repeat (8) step(1);
        check("t5_reads", reads_total - r0, 1);
        check("t5_valid_cycles", valid_cycles - v0, 1);
        check("t5_drain", expq.size(), 0);

        // Reset mid-stream with a read in flight
        for (int unsigned i = 0; i < 6; i++) push_word(16'h8000 | 16'(i + 1));
        step(0);
        step(0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("t1");
        clear_model();
        repeat (2) step(1);
        check_reset_outputs("t1_hold");
        reset = 1'b1;
        repeat (10) step(1);
        check("t1_no_words", pops_total, 0);
        check("t1_no_reads", reads_total, 0);

        // Randomised traffic
        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) push_word(16'($urandom));
            if ($urandom_range(0, 3) == 0) push_word(16'($urandom));
            step($urandom_range(0, 1) == 1);
        end
        repeat (bufq.size() + 10) step(1);
        check("rand_drain", expq.size(), 0);
        check("rand_counts", pops_total, reads_total);

`ifdef DRAIN_STATS_EN
        // Statistics: 4 words, 3 stall cycles
        @(negedge clk);
        reset = 1'b0;
        #1;
        clear_model();
        check("t6_words_rst", stat_words_o, 0);
        check("t6_stall_rst", stat_stall_o, 0);
        step(0);
        reset = 1'b1;
        for (int unsigned i = 0; i < 4; i++) push_word(16'($urandom));
        repeat (5) step(0);
        repeat (8) step(1);
        check("t6_words", stat_words_o, 4);
        check("t6_stall", stat_stall_o, 3);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
